// File: rtl/seg_scan_display_if.sv
// Capture/status bundle between the result bus and the display driver.
// The datapath drives value/load/sign_en; the driver reports busy/ovf.
interface seg_scan_display_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] value;
  logic             load;
  logic             sign_en;
  logic             busy;
  logic             ovf;

  modport master (
    output value, load, sign_en,
    input  busy, ovf
  );

  modport slave (
    input  value, load, sign_en,
    output busy, ovf
  );
endinterface

// File: rtl/seg_scan_display.sv
// Multiplexed common-anode seven-segment driver with a serial
// double-dabble binary-to-BCD converter and sign/overflow handling.
module seg_scan_display #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 8,
  parameter int DIV    = 32
)(
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_display_if.slave bus,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int ND = (WIDTH * 302 + 999) / 1000 + 1;
  localparam int BW = ND * 4;
  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int KW = $clog2(WIDTH + 1);

  localparam logic [6:0] G_DASH  = 7'b0111111;
  localparam logic [6:0] G_E     = 7'b0000110;
  localparam logic [6:0] G_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_COMMIT
  } state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_mag;
  logic [BW-1:0]    r_bcd;
  logic [KW-1:0]    r_bit;
  logic             r_sen, r_negc;
  logic [BW-1:0]    r_dig;
  logic             r_neg, r_sgn, r_ovf;
  logic [CW-1:0]    r_cnt;
  logic [IW-1:0]    r_idx;
  logic [6:0]       r_seg;
  logic [DIGITS-1:0] r_an;
  logic             w_ovf, w_nz, w_isneg;
  logic [3:0]       w_dsel;
  logic [6:0]       w_glyph;
  logic [WIDTH-1:0] w_negv;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return G_BLANK;
    endcase
  endfunction

  // Add-3 on every nibble >= 5, then shift one magnitude bit in.
  function automatic logic [BW-1:0] f_step(
    input logic [BW-1:0] b,
    input logic          s
  );
    logic [BW-1:0] a;
    for (int i = 0; i < ND; i++)
      a[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ?
                    b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    return {a[BW-2:0], s};
  endfunction

  assign w_isneg  = bus.sign_en & bus.value[WIDTH-1];
  assign w_negv   = -bus.value;
  assign bus.busy = (r_state != S_IDLE);
  assign bus.ovf  = r_ovf;
  assign seg      = r_seg;
  assign an       = r_an;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.load) w_next = S_CONV;
      S_CONV:   if (r_bit == KW'(WIDTH - 1)) w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_ovf = 1'b0;
    for (int i = 0; i < ND; i++)
      if (i >= (r_sen ? DIGITS - 1 : DIGITS) &&
          r_bcd[i*4 +: 4] != 4'd0)
        w_ovf = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag  <= '0;
      r_bcd  <= '0;
      r_bit  <= '0;
      r_sen  <= 1'b0;
      r_negc <= 1'b0;
      r_dig  <= '0;
      r_neg  <= 1'b0;
      r_sgn  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (bus.load) begin
          r_sen  <= bus.sign_en;
          r_negc <= w_isneg;
          r_mag  <= w_isneg ? w_negv : bus.value;
          r_bcd  <= '0;
          r_bit  <= '0;
        end
        S_CONV: begin
          r_bcd <= f_step(r_bcd, r_mag[WIDTH-1]);
          r_mag <= r_mag << 1;
          r_bit <= r_bit + 1'b1;
        end
        S_COMMIT: begin
          r_dig <= r_bcd;
          r_neg <= r_negc;
          r_sgn <= r_sen;
          r_ovf <= w_ovf;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_dsel = 4'd0;
    w_nz   = 1'b0;
    for (int i = 0; i < ND; i++) begin
      if (i == int'(r_idx)) w_dsel = r_dig[i*4 +: 4];
      if (i >= int'(r_idx) && r_dig[i*4 +: 4] != 4'd0)
        w_nz = 1'b1;
    end
  end

  always_comb begin
    w_glyph = G_BLANK;
    if (r_ovf) begin
      if (r_idx == '0) w_glyph = G_E;
    end else if (r_sgn && int'(r_idx) == DIGITS - 1) begin
      if (r_neg) w_glyph = G_DASH;
    end else if (r_idx == '0 || w_nz) begin
      w_glyph = f_seg(w_dsel);
    end
  end

  // Two dark cycles at the start of every slot hide ghosting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_an  <= '1;
      r_seg <= G_BLANK;
    end else begin
      if (r_cnt == CW'(DIV - 1)) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IW'(DIGITS - 1)) ?
                 '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_cnt < CW'(2)) begin
        r_an  <= '1;
        r_seg <= G_BLANK;
      end else begin
        r_an  <= ~(DIGITS'(1) << r_idx);
        r_seg <= w_glyph;
      end
    end
  end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised successor to the design's fixed four-digit seven-segment driver. It captures a binary value on a strobe and converts it to BCD sequentially (shift-and-add-3, one bit per clock), with optional two's-complement sign handling, leading-zero blanking and overflow indication. It continuously time-multiplexes the committed digits onto the board's common-anode display. It sits between the datapath result bus (e.g. the ALU output) and the board `seg`/`an` pins.

## Interface
- `DIGITS`, 4: number of physical digits, 2..8.
- `WIDTH`, 8: binary input width, 4..16.
- `DIV`, 32: clock cycles per digit slot, ≥ 4.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `value`  in  WIDTH  binary number to display.
- `load`  in  1  capture strobe; accepted only when `busy`=0.
- `sign_en`  in  1  1: treat `value` as two's complement; sampled with `value`.
- `busy`  out  1  conversion in progress.
- `ovf`  out  1  committed value does not fit in the available digits.
- `seg`  out  7  {g,f,e,d,c,b,a}, active-low, registered.
- `an`  out  DIGITS  digit enables, active-low one-hot, registered.

## Operation
- Capture: on `load`=1 with `busy`=0, latch `sign_en`. If `sign_en`=1 and `value[WIDTH-1]`=1, set neg=1 and magnitude=−value (WIDTH bits, so −2^(WIDTH−1) gives 2^(WIDTH−1)). Otherwise set neg=0 and magnitude=value.
- Convert: the internal BCD register holds ceil(WIDTH·0.302)+1 digits. Each cycle, add 3 to every nibble ≥5, then shift in the next magnitude bit, MSB first. WIDTH iterations in total.
- Commit: one cycle after the last shift, copy digits, neg and the ovf decision into the display register atomically. During conversion, the previous committed contents stay on the display.
- Available digits: avail = DIGITS−1 if the latched sign_en=1, otherwise DIGITS. ovf=1 if any BCD digit at position ≥ avail is nonzero.
- Glyph per digit position k:
  - When ovf=1, digit 0 shows 'E' and all other digits are blank.
  - Otherwise, digit k (k < avail) shows its BCD glyph. It is blank if k > 0 and all digits at positions ≥ k are zero.
  - With sign_en=1, digit DIGITS−1 shows '-' when neg=1 and blank otherwise.
- Glyph codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, '-'=0111111, 'E'=0000110, blank=1111111.
- Scan:
  - cnt counts 0..DIV−1. When it wraps, idx advances, and idx wraps from DIGITS−1 to 0.
  - Ghost suppression: while cnt ∈ {0,1}, `an` is all ones. Otherwise `an`=~(1<<idx) and `seg`=glyph(idx).
  - Scan runs independently of conversion.
- `load` while `busy`=1 is ignored and is not queued.

## Timing
- Reset values:
  - `an` all ones, `seg`=1111111, `busy`=0, `ovf`=0, cnt=0, idx=0.
  - Committed display = value 0, neg=0, so after scanning, digit 0 shows '0' and the rest are blank.
- `rst_n` low mid-conversion aborts the conversion and restores the reset state. No partial commit.
- Load at edge T: `busy`=1 from T+1 for exactly WIDTH+1 cycles, and commit occurs at edge T+WIDTH+1. `busy`=0 and `ovf` are valid after that edge. A new `load` is accepted at that same edge.
- `seg`/`an` reflect the registered state one cycle after cnt/idx. A changed glyph first appears in the next non-blanked cycle of that digit's slot.
- Full refresh period is DIGITS·DIV cycles, and the enabled time per digit is DIV−2 cycles.

## Test plan
- Reset, then release (DIGITS=4, WIDTH=8, DIV=32) → `an`=1111 and `seg`=1111111 during reset. In the first slot, from cnt=2, `an`=1110 and `seg`=1000000. Digits 1–3 are blank in their slots.
- `value`=173, `sign_en`=0, one-cycle `load` → `busy` high for 9 cycles. Then digit2=1111001, digit1=1111000, digit0=0110000, digit3 blank, `ovf`=0.
- `value`=8'hF6, `sign_en`=1 → digit3 '-' (0111111), digit2 blank, digit1 '1', digit0 '0'. `value`=8'h80 → '-' then 1,2,8.
- DIGITS=2, `value`=255 unsigned → `ovf`=1, digit0 'E' (0000110), digit1 blank. Then `value`=99 → `ovf`=0, display "99".
- Second `load` (value 5) issued 3 cycles into a conversion of 42 → ignored, display "42". `rst_n` pulsed mid-conversion of 200 → display "0", `busy`=0.
- Scan check over 3·DIGITS·DIV cycles → every `an` enable pattern is one-hot or all ones, and each digit is enabled exactly DIV−2 consecutive cycles per period.
